// File: rtl/otter_branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : otter_branch_predictor
//  Description : Direct-mapped branch target buffer with one 2-bit saturating
//                counter per entry. Combinational lookup for fetch, resolved
//                outcome write-back and mispredict detection for decode, plus
//                saturating performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module otter_branch_predictor #(
    parameter int         ENTRIES  = 16,
    parameter logic [1:0] CTR_INIT = 2'b01
) (
    input  logic        CLK,
    input  logic        RST,
    // fetch-side lookup
    input  logic [31:0] if_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_next_pc,
    // decode-side resolution
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_is_branch,
    input  logic        upd_is_jump,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_next_pc,
    output logic        mispredict,
    // maintenance and statistics
    input  logic        bp_clear,
    output logic [31:0] stat_updates,
    output logic [31:0] stat_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    // Table storage: valid/ctr need a defined value after reset/clear,
    // tag/target/jmp are only meaningful under a valid bit.
    logic [ENTRIES-1:0] r_valid;
    logic [1:0]         r_ctr    [ENTRIES];
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [31:0]        r_target [ENTRIES];
    logic [ENTRIES-1:0] r_jmp;

    logic [31:0]        r_stat_updates;
    logic [31:0]        r_stat_mispredicts;

    // ---------------- fetch lookup ----------------
    logic [IDX_W-1:0] w_if_idx;
    logic [TAG_W-1:0] w_if_tag;

    assign w_if_idx     = if_pc[IDX_W+1:2];
    assign w_if_tag     = if_pc[31:IDX_W+2];
    assign pred_hit     = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign pred_taken   = pred_hit && (r_jmp[w_if_idx] || r_ctr[w_if_idx][1]);
    assign pred_next_pc = pred_taken ? r_target[w_if_idx] : (if_pc + 32'd4);

    // ---------------- resolution ----------------
    logic [IDX_W-1:0] w_upd_idx;
    logic [TAG_W-1:0] w_upd_tag;
    logic             w_upd_hit;
    logic             w_act_taken;
    logic [31:0]      w_act_next;
    logic             w_counted;
    logic             w_wr_en;
    logic             w_alloc;
    logic             w_br_hit;
    logic [1:0]       w_ctr_cur;
    logic [1:0]       w_ctr_next;

    assign w_upd_idx   = upd_pc[IDX_W+1:2];
    assign w_upd_tag   = upd_pc[31:IDX_W+2];
    assign w_upd_hit   = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

    // Mispredict uses only the carried prediction and the resolved outcome.
    assign w_act_taken = upd_is_jump || (upd_is_branch && upd_taken);
    assign w_act_next  = w_act_taken ? upd_target : (upd_pc + 32'd4);
    assign mispredict  = upd_valid && (upd_is_branch || upd_is_jump || upd_pred_taken)
                         && (upd_pred_next_pc != w_act_next);
    assign w_counted   = upd_valid && (upd_is_branch || upd_is_jump);

    // Clear and reset suppress every table write in their cycle.
    assign w_wr_en  = upd_valid && !RST && !bp_clear;
    // Jumps always (re)install; taken branches install on a miss.
    assign w_alloc  = w_wr_en && (upd_is_jump || (upd_is_branch && !w_upd_hit && upd_taken));
    assign w_br_hit = w_wr_en && !upd_is_jump && upd_is_branch && w_upd_hit;

    assign w_ctr_cur  = r_ctr[w_upd_idx];
    assign w_ctr_next = upd_taken ? ((w_ctr_cur == 2'b11) ? 2'b11 : w_ctr_cur + 2'd1)
                                  : ((w_ctr_cur == 2'b00) ? 2'b00 : w_ctr_cur - 2'd1);

    // Valid bits and counters: invalidate on reset/clear, else apply outcome.
    always_ff @(posedge CLK) begin
        if (RST || bp_clear) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= CTR_INIT;
            end
        end else if (upd_valid) begin
            if (upd_is_jump) begin
                r_valid[w_upd_idx] <= 1'b1;
                r_ctr[w_upd_idx]   <= 2'b11;
            end else if (upd_is_branch) begin
                if (w_upd_hit) begin
                    r_ctr[w_upd_idx] <= w_ctr_next;
                end else if (upd_taken) begin
                    r_valid[w_upd_idx] <= 1'b1;
                    r_ctr[w_upd_idx]   <= 2'b10;
                end
            end else if (w_upd_hit) begin
                // a non-control instruction hit a stale or aliased entry
                r_valid[w_upd_idx] <= 1'b0;
            end
        end
    end

    // Tag, target and jump flag: written on allocation or a branch hit.
    always_ff @(posedge CLK) begin
        if (w_alloc) begin
            r_tag[w_upd_idx]    <= w_upd_tag;
            r_target[w_upd_idx] <= upd_target;
            r_jmp[w_upd_idx]    <= upd_is_jump;
        end else if (w_br_hit) begin
            r_jmp[w_upd_idx] <= 1'b0;
            if (upd_taken) begin
                r_target[w_upd_idx] <= upd_target;
            end
        end
    end

    // Saturating statistics, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stat_updates     <= '0;
            r_stat_mispredicts <= '0;
        end else begin
            if (w_counted && (r_stat_updates != 32'hFFFF_FFFF)) begin
                r_stat_updates <= r_stat_updates + 32'd1;
            end
            if (mispredict && (r_stat_mispredicts != 32'hFFFF_FFFF)) begin
                r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
            end
        end
    end

    assign stat_updates     = r_stat_updates;
    assign stat_mispredicts = r_stat_mispredicts;

endmodule
`default_nettype wire
